// File: rtl/logger_pkg.sv
// Definitions shared by the event logger stages: ASCII framing characters,
// the UART transmitter state encoding and a baud divisor helper.
package logger_pkg;

    localparam logic [7:0] ASCII_COMMA   = 8'h2C;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Rounds to the nearest whole number of clocks per bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/logger_baud_gen.sv
// Bit-period timer for the logger UART: counts clocks within one bit and
// flags the last clock of the bit so the FSM can advance.
module logger_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (clear) begin
            baud_cnt <= '0;
        end else if (enable) begin
            if (baud_cnt == LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

    assign bit_done = enable && (baud_cnt == LAST);

endmodule

// File: rtl/logger_uart_tx.sv
// Drains ASCII bytes from the logger FIFO and sends each as an 8N1/8N2 UART
// frame, counting completed bytes and completed lines (newline bytes).
//
// state | meaning
// IDLE  | line high; pop the FIFO when it has data
// FETCH | capture the popped byte (read latency 1)
// START | start bit, line low for one bit period
// DATA  | eight data bits, LSB first
// STOP  | STOP_BITS bit periods high, then update counters
module logger_uart_tx
    import logger_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int STOP_BITS   = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_dout,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic [CNT_W-1:0] bytes_sent,
    output logic [CNT_W-1:0] lines_sent
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam logic [2:0] LAST_DATA    = 3'd7;
    localparam logic [2:0] LAST_STOP    = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("logger_uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("logger_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t state;
    logic [7:0]  shreg;
    logic [7:0]  byte_q;
    logic [2:0]  bit_idx;
    logic        bit_done;
    logic        baud_clear;
    logic        baud_en;

    assign baud_clear = (state == IDLE) || (state == FETCH);
    assign baud_en    = (state == START) || (state == DATA) || (state == STOP);

    logger_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .enable  (baud_en),
        .bit_done(bit_done)
    );

    // Gated by rst_n so nothing is popped while reset is held.
    assign fifo_rd_en = rst_n && (state == IDLE) && !fifo_empty;
    assign tx_busy    = (state != IDLE);

    // uart_txd is loaded with the level of the state being entered, so the
    // pin is a pure flop output aligned to the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            uart_txd   <= 1'b1;
            shreg      <= '0;
            byte_q     <= '0;
            bit_idx    <= '0;
            bytes_sent <= '0;
            lines_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (!fifo_empty) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    shreg    <= fifo_dout;
                    byte_q   <= fifo_dout;
                    uart_txd <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_done) begin
                        bit_idx  <= '0;
                        uart_txd <= shreg[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx  <= '0;
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    uart_txd <= 1'b1;
                    if (bit_done) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx    <= '0;
                            bytes_sent <= bytes_sent + CNT_W'(1);
                            if (byte_q == ASCII_NEWLINE) begin
                                lines_sent <= lines_sent + CNT_W'(1);
                            end
                            state <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
